// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-facing signal bundle for sync_fifo_param.
// master = the block(s) that write and read the FIFO; slave = the FIFO itself.
interface sync_fifo_param_if #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr;
  logic [DWIDTH-1:0] din;
  logic              rd;
  logic [DWIDTH-1:0] dout;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, din, rd,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr, din, rd,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered flags, occupancy count and error pulses.
// Latency: 1-cycle registered read; FIFO_FWFT_EN selects first-word-fall-through dout.
// Backpressure: writes dropped while full (overflow pulse), reads dropped while empty (underflow pulse).
module sync_fifo_param #(
  parameter int DWIDTH   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              reset,
  sync_fifo_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_nxt;
  logic              full_q;
  logic              empty_q;
  logic              af_q;
  logic              ae_q;
  logic              ovf_q;
  logic              udf_q;
  logic              wr_acc;
  logic              rd_acc;

  // Acceptance uses the registered flags, so a full FIFO never bypasses a write into a same-cycle read slot.
  assign wr_acc = bus.wr && !full_q;
  assign rd_acc = bus.rd && !empty_q;

  always_comb begin
    count_nxt = count_q;
    if (wr_acc && !rd_acc) begin
      count_nxt = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wptr] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rptr <= rptr + 1'b1;
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == FULL_CNT);
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= AF_CNT);
      ae_q    <= (count_nxt <= AE_CNT);
      ovf_q   <= bus.wr && full_q;
      udf_q   <= bus.rd && empty_q;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.dout = empty_q ? '0 : mem[rptr];
`else
  logic [DWIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= mem[rptr];
    end
  end

  assign bus.dout = dout_q;
`endif

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DWIDTH=8, DEPTH=16, AF=14, AE=2); build with
// FIFO_FWFT_EN defined to check the fall-through read mode instead of the registered one.
module tb_sync_fifo_param;
`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DWIDTH(8), .DEPTH(16)) bus ();

  sync_fifo_param #(
    .DWIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst, wr, rd;
    logic [7:0] din;
    logic [4:0] cnt;
    logic       emp, ae, af, ful, ovf, udf;
    logic [7:0] dout;
  } vec_t;

  vec_t tv[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mq[$];
  logic [7:0] mdout_std = 8'h00;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rst, logic wr, logic rd, logic [7:0] din, int cnt,
                              logic ovf, logic udf, logic [7:0] dout);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.din = din;
    v.cnt = 5'(cnt);
    v.emp = (cnt == 0);
    v.ae  = (cnt <= 2);
    v.af  = (cnt >= 14);
    v.ful = (cnt == 16);
    v.ovf = ovf; v.udf = udf; v.dout = dout;
    return v;
  endfunction

  task automatic drive_step(input logic rst, input logic wr, input logic rd, input logic [7:0] din);
    reset   = rst;
    bus.wr  = wr;
    bus.rd  = rd;
    bus.din = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input int idx, input int cnt, input logic emp, input logic ae,
                               input logic af, input logic ful, input logic ovf, input logic udf,
                               input logic [7:0] dout);
    chk("count",        idx, 32'(bus.count),        32'(cnt));
    chk("empty",        idx, 32'(bus.empty),        32'(emp));
    chk("almost_empty", idx, 32'(bus.almost_empty), 32'(ae));
    chk("almost_full",  idx, 32'(bus.almost_full),  32'(af));
    chk("full",         idx, 32'(bus.full),         32'(ful));
    chk("overflow",     idx, 32'(bus.overflow),     32'(ovf));
    chk("underflow",    idx, 32'(bus.underflow),    32'(udf));
    chk("dout",         idx, 32'(bus.dout),         32'(dout));
  endtask

  // Reference queue for the multi-cycle sequences: applies the accept rules to the pre-edge occupancy.
  task automatic model_op(input int idx, input logic rst, input logic wr, input logic rd, input logic [7:0] din);
    int   pre;
    logic ovf, udf;
    logic [7:0] exp_dout;
    pre = mq.size();
    drive_step(rst, wr, rd, din);
    ovf = 1'b0;
    udf = 1'b0;
    if (rst) begin
      mq.delete();
      mdout_std = 8'h00;
    end else begin
      ovf = wr && (pre == 16);
      udf = rd && (pre == 0);
      if (rd && pre != 0) mdout_std = mq.pop_front();
      if (wr && pre != 16) mq.push_back(din);
    end
    if (FWFT) exp_dout = (mq.size() == 0) ? 8'h00 : mq[0];
    else      exp_dout = mdout_std;
    check_outputs(idx, mq.size(), mq.size() == 0, mq.size() <= 2, mq.size() >= 14,
                  mq.size() == 16, ovf, udf, exp_dout);
  endtask

  initial begin
    int n;
    reset   = 1'b1;
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
    bus.din = 8'h00;

    // Reset with requests pending, fill to full plus one, drain, then one extra read.
    tv.push_back(mk(1, 1, 1, 8'h55, 0, 0, 0, 8'h00));
    tv.push_back(mk(1, 1, 1, 8'h55, 0, 0, 0, 8'h00));
    for (int k = 1; k <= 16; k++)
      tv.push_back(mk(0, 1, 0, 8'(k), k, 0, 0, FWFT ? 8'd1 : 8'd0));
    tv.push_back(mk(0, 1, 0, 8'd99, 16, 1, 0, FWFT ? 8'd1 : 8'd0));
    tv.push_back(mk(0, 0, 0, 8'd0,  16, 0, 0, FWFT ? 8'd1 : 8'd0));
    for (int k = 1; k <= 16; k++)
      tv.push_back(mk(0, 0, 1, 8'd0, 16 - k, 0, 0,
                      FWFT ? ((k == 16) ? 8'd0 : 8'(k + 1)) : 8'(k)));
    tv.push_back(mk(0, 0, 1, 8'd0, 0, 0, 1, FWFT ? 8'd0 : 8'd16));
    tv.push_back(mk(0, 0, 0, 8'd0, 0, 0, 0, FWFT ? 8'd0 : 8'd16));

    for (int i = 0; i < tv.size(); i++) begin
      drive_step(tv[i].rst, tv[i].wr, tv[i].rd, tv[i].din);
      check_outputs(i, tv[i].cnt, tv[i].emp, tv[i].ae, tv[i].af, tv[i].ful,
                    tv[i].ovf, tv[i].udf, tv[i].dout);
    end

    n = 1000;
    // Simultaneous read/write at count 5 across pointer wrap.
    model_op(n++, 1, 0, 0, 8'h00);
    for (int i = 1; i <= 5; i++) model_op(n++, 0, 1, 0, 8'(i));
    for (int i = 0; i < 20; i++) model_op(n++, 0, 1, 1, 8'(100 + i));

    // wr+rd on empty: write wins, read rejected.
    model_op(n++, 1, 0, 0, 8'h00);
    model_op(n++, 0, 1, 1, 8'h33);

    // wr+rd on full: read wins, write rejected.
    for (int i = 0; i < 15; i++) model_op(n++, 0, 1, 0, 8'(i + 64));
    model_op(n++, 0, 1, 1, 8'h44);
    model_op(n++, 0, 0, 0, 8'h00);

    // Reset mid-stream discards the nine stored words.
    model_op(n++, 1, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) model_op(n++, 0, 1, 0, 8'(i + 200));
    model_op(n++, 1, 1, 0, 8'h77);
    model_op(n++, 0, 1, 0, 8'hA5);
    model_op(n++, 0, 0, 1, 8'h00);

    // Two-word write then two reads: fall-through vs registered dout.
    model_op(n++, 0, 1, 0, 8'h11);
    model_op(n++, 0, 1, 0, 8'h22);
    model_op(n++, 0, 0, 0, 8'h00);
    model_op(n++, 0, 0, 1, 8'h00);
    model_op(n++, 0, 0, 1, 8'h00);
    model_op(n++, 0, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO; next generation of the team's 8-bit synchronous FIFO. Adds configurable data width and depth, programmable almost-full/almost-empty thresholds, an occupancy count, and registered overflow/underflow error pulses. Sits between any two same-clock producer/consumer blocks and is the standard buffer for new datapaths; optional first-word-fall-through read mode.

## Interface
- DWIDTH, 8, data word width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=4
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- wr  input  1  write request
- din  input  DWIDTH  write data, sampled on accepted write
- rd  input  1  read request
- dout  output  DWIDTH  read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: write rejected last cycle
- underflow  output  1  one-cycle pulse: read rejected last cycle

## Operation
- Storage: DEPTH x DWIDTH array; write pointer and read pointer, each $clog2(DEPTH) bits, wrap modulo DEPTH naturally; count held in a separate register.
- Write accepted iff wr && !full (full = value before the edge). Accepted: mem[wptr] <= din, wptr++.
- Read accepted iff rd && !empty (empty = value before the edge). Accepted: rptr++.
- Simultaneous wr && rd, neither full nor empty: both accepted, count unchanged.
- wr && rd while empty: write accepted, read rejected, underflow pulses. wr && rd while full: read accepted, write rejected, overflow pulses. No bypass of either flag.
- count: +1 on write-only accept, -1 on read-only accept, unchanged otherwise.
- All flags (full, empty, almost_full, almost_empty) are registered, derived from the next count value, so they are exact in the cycle after each edge.
- overflow <= wr && full; underflow <= rd && empty; each high for exactly one cycle per rejected request; back-to-back rejections hold them high.
- Rejected operations change no pointer, count, or data.
- Reset (synchronous, dominates wr/rd in the same cycle): pointers 0, count 0, empty 1, almost_empty 1 (AE_LEVEL >= 0), full 0, almost_full 0, overflow 0, underflow 0, dout 0. Memory contents not cleared. Reset mid-stream discards all stored words.

## Timing
- Standard mode: dout registered; on accepted read at edge N, dout shows head word after edge N (1-cycle read latency). dout holds its value when no read is accepted.
- Write at edge N into empty FIFO: empty deasserts after edge N; earliest accepted read at edge N+1; data on dout after edge N+1.
- Full deasserts the cycle after the first accepted read; empty asserts the cycle after the last accepted read.
- Throughput: one write and one read per cycle sustained.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through. dout continuously shows mem[rptr] whenever empty=0 (combinational from storage/pointer), 0 when empty=1. Word written at edge N is visible on dout after edge N; accepted read at edge M advances dout to next word after edge M. All other behaviour identical.
- FIFO_FWFT_EN undefined: standard registered read as in Timing.

## Test plan
(DWIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2 unless noted)
- Reset: assert reset 2 cycles with wr=rd=1 -> count=0, empty=1, almost_empty=1, full=0, overflow=underflow=0, dout=0.
- Fill: write 1..16 on consecutive cycles -> almost_empty drops after 3rd write, almost_full rises after 14th, full after 16th, count=16; 17th write (din=99) -> overflow pulses one cycle, count stays 16.
- Drain order: from full, rd for 16 cycles -> dout 1..16 in order (standard: one cycle after each read edge), empty after 16th; extra rd -> underflow pulse, dout stays 16.
- Simultaneous: with count=5, wr+rd for 20 cycles din=100..119 -> count stays 5, output order preserved across pointer wrap; wr+rd on empty -> count=1, underflow=1; wr+rd on full -> count=15, overflow=1.
- Reset mid-operation: count=9, assert reset with wr=1 -> count=0, empty=1; next write 0xA5 then read -> dout=0xA5.
- FWFT build (FIFO_FWFT_EN): write 0x11, 0x22 -> dout=0x11 cycle after first write with no rd; one rd -> dout=0x22; second rd -> empty=1, dout=0.
